ghost_target_ctrl: RTL and testbench

GHOST_TARGET_CTRL -- requirements
Module: ghost_target_ctrl

---
 rtl/ghost_pkg.sv | 26 ++
 rtl/ghost_target_ctrl_if.sv | 28 ++
 rtl/ghost_lfsr.sv | 16 +
 rtl/ghost_target_ctrl.sv | 156 +++++++++++++++
 tb/tb_ghost_target_ctrl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ghost_pkg.sv
// Shared types and maze limits for the ghost target pipeline.
package ghost_pkg;

  localparam int unsigned COORD_W    = 5;
  localparam int unsigned MAZE_MAX_X = 27;
  localparam int unsigned MAZE_MAX_Y = 30;

  typedef enum logic [1:0] {
    SCATTER = 2'd0,
    CHASE   = 2'd1,
    FRIGHT  = 2'd2,
    EATEN   = 2'd3
  } ghost_mode_e;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_e;

  function automatic logic [COORD_W-1:0] sat_coord(input logic [5:0] v, input logic [5:0] lim);
    return (v > lim) ? lim[COORD_W-1:0] : v[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/ghost_target_ctrl_if.sv
// Game-step inputs and target outputs of the ghost target controller.
interface ghost_target_ctrl_if;
  import ghost_pkg::*;

  logic               tick;
  logic [COORD_W-1:0] pacPosX;
  logic [COORD_W-1:0] pacPosY;
  logic [1:0]         pacDir;
  logic [COORD_W-1:0] ghostPosX;
  logic [COORD_W-1:0] ghostPosY;
  logic               powerPellet;
  logic               ghostEaten;
  logic [COORD_W-1:0] targetPosX;
  logic [COORD_W-1:0] targetPosY;
  logic [1:0]         mode;
  logic               update;

  modport master (
    output tick, pacPosX, pacPosY, pacDir, ghostPosX, ghostPosY, powerPellet, ghostEaten,
    input  targetPosX, targetPosY, mode, update
  );

  modport slave (
    input  tick, pacPosX, pacPosY, pacDir, ghostPosX, ghostPosY, powerPellet, ghostEaten,
    output targetPosX, targetPosY, mode, update
  );

endinterface

// File: rtl/ghost_lfsr.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, stepping when en is high.
module ghost_lfsr (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [7:0] out
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      out <= 8'hA5;
    else if (en)
      out <= {out[6:0], out[7] ^ out[5] ^ out[4] ^ out[3]};
  end

endmodule

// File: rtl/ghost_target_ctrl.sv
// Ghost mode FSM and target-tile selection; targets land the cycle after a tick,
// the move-step pulse one cycle later.
module ghost_target_ctrl
  import ghost_pkg::*;
#(
  parameter logic [COORD_W-1:0] SCATTER_X     = 5'd25,
  parameter logic [COORD_W-1:0] SCATTER_Y     = 5'd0,
  parameter logic [COORD_W-1:0] HOME_X        = 5'd13,
  parameter logic [COORD_W-1:0] HOME_Y        = 5'd14,
  parameter int unsigned        SCATTER_TICKS = 420,
  parameter int unsigned        CHASE_TICKS   = 1200,
  parameter int unsigned        FRIGHT_TICKS  = 360,
  parameter bit                 AHEAD         = 1'b0
) (
  input logic                clk,
  input logic                reset,
  ghost_target_ctrl_if.slave gif
);

  ghost_mode_e        state, state_n, saved, saved_n;
  logic [2:0]         phase, phase_n;
  logic [15:0]        timer, timer_n, ftimer, ftimer_n;
  logic               pend_pp, pend_ge, tick_q, upd_q;
  logic [COORD_W-1:0] tgt_x, tgt_y, tgt_x_n, tgt_y_n;
  logic [7:0]         lfsr;
  logic               pp_ev, ge_ev, at_home;
  logic [5:0]         ax6, ay6;

  ghost_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (gif.tick),
    .out   (lfsr)
  );

  // Pulses arriving between ticks are held and acted on at the next tick.
  assign pp_ev   = pend_pp | gif.powerPellet;
  assign ge_ev   = pend_ge | gif.ghostEaten;
  assign at_home = (gif.ghostPosX == HOME_X) && (gif.ghostPosY == HOME_Y);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= SCATTER;
      saved   <= SCATTER;
      phase   <= '0;
      timer   <= 16'(SCATTER_TICKS);
      ftimer  <= '0;
      pend_pp <= 1'b0;
      pend_ge <= 1'b0;
      tick_q  <= 1'b0;
      upd_q   <= 1'b0;
      tgt_x   <= SCATTER_X;
      tgt_y   <= SCATTER_Y;
    end else begin
      state   <= state_n;
      saved   <= saved_n;
      phase   <= phase_n;
      timer   <= timer_n;
      ftimer  <= ftimer_n;
      pend_pp <= gif.tick ? 1'b0 : (pend_pp | gif.powerPellet);
      pend_ge <= gif.tick ? 1'b0 : (pend_ge | gif.ghostEaten);
      tick_q  <= gif.tick;
      upd_q   <= tick_q;
      if (gif.tick) begin
        tgt_x <= tgt_x_n;
        tgt_y <= tgt_y_n;
      end
    end
  end

  always_comb begin
    state_n  = state;
    saved_n  = saved;
    phase_n  = phase;
    timer_n  = timer;
    ftimer_n = ftimer;
    if (gif.tick) begin
      unique case (state)
        SCATTER, CHASE: begin
          if (pp_ev) begin
            saved_n  = state;
            state_n  = FRIGHT;
            ftimer_n = 16'(FRIGHT_TICKS);
          end else if (phase != 3'd7) begin
            if (timer <= 16'd1) begin
              phase_n = phase + 3'd1;
              state_n = (state == SCATTER) ? CHASE : SCATTER;
              timer_n = (state == SCATTER) ? 16'(CHASE_TICKS) : 16'(SCATTER_TICKS);
            end else begin
              timer_n = timer - 16'd1;
            end
          end
        end
        FRIGHT: begin
          if (ge_ev) begin
            state_n  = EATEN;
            ftimer_n = '0;
          end else if (pp_ev) begin
            ftimer_n = 16'(FRIGHT_TICKS);
          end else if (ftimer <= 16'd1) begin
            state_n  = saved;
            ftimer_n = '0;
          end else begin
            ftimer_n = ftimer - 16'd1;
          end
        end
        EATEN: begin
          if (at_home)
            state_n = saved;
        end
      endcase
    end
  end

  always_comb begin
    ax6 = {1'b0, gif.pacPosX};
    ay6 = {1'b0, gif.pacPosY};
    unique case (dir_e'(gif.pacDir))
      UP:    ay6 = (ay6 < 6'd4) ? '0 : ay6 - 6'd4;
      DOWN:  ay6 = ay6 + 6'd4;
      LEFT:  ax6 = (ax6 < 6'd4) ? '0 : ax6 - 6'd4;
      RIGHT: ax6 = ax6 + 6'd4;
    endcase
    tgt_x_n = SCATTER_X;
    tgt_y_n = SCATTER_Y;
    unique case (state_n)
      SCATTER: begin
        tgt_x_n = SCATTER_X;
        tgt_y_n = SCATTER_Y;
      end
      CHASE: begin
        if (AHEAD) begin
          tgt_x_n = sat_coord(ax6, 6'(MAZE_MAX_X));
          tgt_y_n = sat_coord(ay6, 6'(MAZE_MAX_Y));
        end else begin
          tgt_x_n = gif.pacPosX;
          tgt_y_n = gif.pacPosY;
        end
      end
      FRIGHT: begin
        tgt_x_n = sat_coord({1'b0, lfsr[4:0]}, 6'(MAZE_MAX_X));
        tgt_y_n = sat_coord({1'b0, lfsr[7:3]}, 6'(MAZE_MAX_Y));
      end
      EATEN: begin
        tgt_x_n = HOME_X;
        tgt_y_n = HOME_Y;
      end
    endcase
  end

  assign gif.targetPosX = tgt_x;
  assign gif.targetPosY = tgt_y;
  assign gif.mode       = state;
  assign gif.update     = upd_q;

endmodule

// File: tb/tb_ghost_target_ctrl.sv
// Bench for ghost_target_ctrl: directed table, corner sequences and a random run
// checked against a behavioural model; AHEAD=0 and AHEAD=1 instances share stimulus.
module tb_ghost_target_ctrl;

  localparam int S_T = 7;
  localparam int C_T = 20;
  localparam int F_T = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ghost_target_ctrl_if g0 ();
  ghost_target_ctrl_if g1 ();

  assign g1.tick        = g0.tick;
  assign g1.pacPosX     = g0.pacPosX;
  assign g1.pacPosY     = g0.pacPosY;
  assign g1.pacDir      = g0.pacDir;
  assign g1.ghostPosX   = g0.ghostPosX;
  assign g1.ghostPosY   = g0.ghostPosY;
  assign g1.powerPellet = g0.powerPellet;
  assign g1.ghostEaten  = g0.ghostEaten;

  ghost_target_ctrl #(.SCATTER_TICKS(S_T), .CHASE_TICKS(C_T), .FRIGHT_TICKS(F_T), .AHEAD(1'b0))
    dut0 (.clk(clk), .reset(reset), .gif(g0));
  ghost_target_ctrl #(.SCATTER_TICKS(S_T), .CHASE_TICKS(C_T), .FRIGHT_TICKS(F_T), .AHEAD(1'b1))
    dut1 (.clk(clk), .reset(reset), .gif(g1));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: 0 scatter, 1 chase, 2 fright, 3 eaten; one phase countdown paused outside 0/1.
  int       m_mode, m_resume, m_phase, m_left, m_fleft;
  bit       m_pend_pp, m_pend_ge, m_prev_tick, m_upd;
  int       m_tx[2], m_ty[2];
  bit [7:0] m_lfsr;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic bit [7:0] lfsr_step(input bit [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_resume = 0; m_phase = 0; m_left = S_T; m_fleft = 0;
    m_pend_pp = 0; m_pend_ge = 0; m_prev_tick = 0; m_upd = 0;
    m_tx[0] = 25; m_ty[0] = 0; m_tx[1] = 25; m_ty[1] = 0;
    m_lfsr = 8'hA5;
  endtask

  task automatic model_edge();
    bit t, pp, ge;
    int px, py, dx, dy;
    t  = g0.tick;
    pp = g0.powerPellet;
    ge = g0.ghostEaten;
    m_upd = m_prev_tick;
    m_prev_tick = t;
    if (!t) begin
      m_pend_pp |= pp;
      m_pend_ge |= ge;
      return;
    end
    pp |= m_pend_pp;
    ge |= m_pend_ge;
    m_pend_pp = 0;
    m_pend_ge = 0;
    if (m_mode <= 1) begin
      if (pp) begin
        m_resume = m_mode; m_mode = 2; m_fleft = F_T;
      end else if (m_phase < 7) begin
        m_left--;
        if (m_left <= 0) begin
          m_mode  = 1 - m_mode;
          m_phase++;
          m_left  = (m_mode == 1) ? C_T : S_T;
        end
      end
    end else if (m_mode == 2) begin
      if (ge) begin
        m_mode = 3; m_fleft = 0;
      end else if (pp) begin
        m_fleft = F_T;
      end else begin
        m_fleft--;
        if (m_fleft <= 0) begin m_mode = m_resume; m_fleft = 0; end
      end
    end else if (g0.ghostPosX == 5'd13 && g0.ghostPosY == 5'd14) begin
      m_mode = m_resume;
    end
    px = int'(g0.pacPosX);
    py = int'(g0.pacPosY);
    dx = (g0.pacDir == 2'd1) ? 1 : ((g0.pacDir == 2'd3) ? -1 : 0);
    dy = (g0.pacDir == 2'd2) ? 1 : ((g0.pacDir == 2'd0) ? -1 : 0);
    case (m_mode)
      0: begin m_tx = '{25, 25}; m_ty = '{0, 0}; end
      1: begin
        m_tx[0] = px; m_ty[0] = py;
        m_tx[1] = clampi(px + 4 * dx, 0, 27);
        m_ty[1] = clampi(py + 4 * dy, 0, 30);
      end
      2: begin
        m_tx[0] = clampi(int'(m_lfsr[4:0]), 0, 27);
        m_ty[0] = clampi(int'(m_lfsr[7:3]), 0, 30);
        m_tx[1] = m_tx[0]; m_ty[1] = m_ty[0];
      end
      default: begin m_tx = '{13, 13}; m_ty = '{14, 14}; end
    endcase
    m_lfsr = lfsr_step(m_lfsr);
  endtask

  task automatic compare_all();
    chk("mode0", int'(g0.mode), m_mode);
    chk("mode1", int'(g1.mode), m_mode);
    chk("tx0", int'(g0.targetPosX), m_tx[0]);
    chk("ty0", int'(g0.targetPosY), m_ty[0]);
    chk("tx1", int'(g1.targetPosX), m_tx[1]);
    chk("ty1", int'(g1.targetPosY), m_ty[1]);
    chk("upd0", int'(g0.update), int'(m_upd));
    chk("upd1", int'(g1.update), int'(m_upd));
  endtask

  task automatic cyc(input bit t, input bit pp, input bit ge);
    g0.tick = t; g0.powerPellet = pp; g0.ghostEaten = ge;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    g0.tick = 0; g0.powerPellet = 0; g0.ghostEaten = 0;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_mode", int'(g0.mode), 0);
    chk("rst_tx", int'(g0.targetPosX), 25);
    chk("rst_ty", int'(g0.targetPosY), 0);
    chk("rst_upd", int'(g0.update), 0);
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;
  endtask

  typedef struct {
    bit pp;
    bit ge;
    int gx;
    int gy;
    int mode;
  } row_t;

  row_t rows[$];

  task automatic add(input int n, input bit pp, input bit ge, input int gx, input int gy, input int md);
    row_t r;
    r.pp = pp; r.ge = ge; r.gx = gx; r.gy = gy; r.mode = md;
    repeat (n) rows.push_back(r);
  endtask

  initial begin
    int ex, ey, sw, last;
    reset = 1'b0;
    g0.tick = 0; g0.powerPellet = 0; g0.ghostEaten = 0;
    g0.pacPosX = 5'd10; g0.pacPosY = 5'd20; g0.pacDir = 2'd1;
    g0.ghostPosX = 5'd5; g0.ghostPosY = 5'd5;
    model_reset();
    #2;
    do_reset();

    // One row = idle cycle carrying pulses, tick cycle, idle cycle.
    add(6,  0, 0, 5, 5, 0);
    add(1,  0, 0, 5, 5, 1);
    add(3,  0, 0, 5, 5, 1);
    add(1,  1, 0, 5, 5, 2);
    add(5,  0, 0, 5, 5, 2);
    add(1,  0, 0, 5, 5, 1);
    add(16, 0, 0, 5, 5, 1);
    add(1,  0, 0, 5, 5, 0);
    add(1,  1, 0, 5, 5, 2);
    add(1,  0, 1, 5, 5, 3);
    add(3,  0, 0, 12, 14, 3);
    add(1,  0, 0, 13, 14, 0);
    add(1,  1, 0, 5, 5, 2);
    add(1,  1, 1, 5, 5, 3);
    add(1,  1, 0, 12, 14, 3);
    add(1,  0, 0, 13, 14, 0);
    add(6,  0, 0, 5, 5, 0);
    add(1,  0, 0, 5, 5, 1);

    foreach (rows[i]) begin
      g0.ghostPosX = 5'(rows[i].gx);
      g0.ghostPosY = 5'(rows[i].gy);
      cyc(0, rows[i].pp, rows[i].ge);
      cyc(1, 0, 0);
      chk("row_mode", int'(g0.mode), rows[i].mode);
      chk("row_upd_early", int'(g0.update), 0);
      case (rows[i].mode)
        0:       begin ex = 25; ey = 0;  end
        1:       begin ex = 10; ey = 20; end
        default: begin ex = 13; ey = 14; end
      endcase
      if (rows[i].mode != 2) begin
        chk("row_tx", int'(g0.targetPosX), ex);
        chk("row_ty", int'(g0.targetPosY), ey);
      end
      if (rows[i].mode == 1) chk("row_ahead_x", int'(g1.targetPosX), 14);
      cyc(0, 0, 0);
      chk("row_upd", int'(g0.update), 1);
    end

    // Four more switches reach phase 7, after which chase never ends.
    g0.ghostPosX = 5'd5; g0.ghostPosY = 5'd5;
    sw = 0;
    last = int'(g0.mode);
    for (int k = 0; k < 150; k++) begin
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      if (int'(g0.mode) != last) begin
        sw++;
        last = int'(g0.mode);
      end
    end
    chk("switches_to_perm", sw, 4);
    chk("perm_chase", int'(g0.mode), 1);

    // Ahead targeting with saturation at maze edges.
    g0.pacPosX = 5'd2; g0.pacPosY = 5'd1; g0.pacDir = 2'd3;
    cyc(1, 0, 0); cyc(0, 0, 0);
    chk("ahead_left_x", int'(g1.targetPosX), 0);
    chk("ahead_left_y", int'(g1.targetPosY), 1);
    chk("plain_x", int'(g0.targetPosX), 2);
    g0.pacDir = 2'd0;
    cyc(1, 0, 0); cyc(0, 0, 0);
    chk("ahead_up_x", int'(g1.targetPosX), 2);
    chk("ahead_up_y", int'(g1.targetPosY), 0);
    g0.pacPosX = 5'd25; g0.pacPosY = 5'd28; g0.pacDir = 2'd1;
    cyc(1, 0, 0); cyc(0, 0, 0);
    chk("ahead_right_x", int'(g1.targetPosX), 27);
    g0.pacDir = 2'd2;
    cyc(1, 0, 0); cyc(0, 0, 0);
    chk("ahead_down_y", int'(g1.targetPosY), 30);

    // Reset mid-fright with events pending: pending pellet must be dropped.
    cyc(0, 1, 0); cyc(1, 0, 0);
    chk("fright_before_rst", int'(g0.mode), 2);
    cyc(0, 0, 1); cyc(0, 1, 0);
    do_reset();
    cyc(1, 0, 0);
    chk("pending_dropped", int'(g0.mode), 0);
    cyc(0, 0, 0);

    for (int k = 0; k < 4000; k++) begin
      g0.pacPosX = 5'($urandom_range(0, 27));
      g0.pacPosY = 5'($urandom_range(0, 30));
      g0.pacDir  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        g0.ghostPosX = 5'd13; g0.ghostPosY = 5'd14;
      end else begin
        g0.ghostPosX = 5'($urandom_range(0, 31));
        g0.ghostPosY = 5'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 149) == 0)
        do_reset();
      else
        cyc(1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
